uart_tx_fifo: RTL and testbench

//   UART transmitter with a write-side FIFO. It is the outbound counterpart of the RX+FIFO block.

---
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 8N1 frames, LSB first; pushes into a full FIFO are dropped.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BAUD  = 115200,
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_50m,
  input  logic                  reset,
  input  logic [FIFO_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_wr_en,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int BAUD_DIV = CLK_FREQ / UART_BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_AFULL = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_nxt;
  logic                  push;
  logic                  pop;
  logic [7:0]            head;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic [7:0]    sh;
  logic [7:0]    sh_nxt;
  logic          tx_nxt;
  logic          busy_nxt;
  logic          bit_end;

  // A full FIFO refuses the write even when the serialiser pops in the same cycle.
  assign push = fifo_wr_en && !fifo_full;
  assign head = mem[rd_ptr][7:0];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      fifo_empty       <= 1'b1;
      fifo_full        <= 1'b0;
      fifo_almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count            <= count_nxt;
      fifo_empty       <= (count_nxt == '0);
      fifo_full        <= (count_nxt == CNT_FULL);
      fifo_almost_full <= (count_nxt >= CNT_AFULL);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= fifo_data_in;
  end

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud_cnt + CW'(1);
    bit_nxt   = bit_idx;
    sh_nxt    = sh;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    busy_nxt  = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          sh_nxt    = head;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          state_nxt = S_DATA;
          bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        tx_nxt = sh[bit_idx];
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_nxt = ^sh;
        if (bit_end) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        tx_nxt = 1'b1;
        // Back-to-back frames: the next byte is taken at the stop-bit boundary.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            sh_nxt    = head;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      sh       <= sh_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based FIFO/transmitter timing model, serial-line decoder,
// table-driven single-frame waveforms and hand-written burst / overlap / reset sequences.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 50000000;
  localparam int UART_BAUD = 3000000;
  localparam int BD = 16;             // 50e6 / 3e6 = 16.67, truncated
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FB = NBITS * BD;

  logic       clk_50m = 1'b0;
  logic       reset;
  logic [7:0] fifo_data_in;
  logic       fifo_wr_en;
  logic       fifo_full, fifo_empty, fifo_almost_full, tx, tx_busy;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ), .UART_BAUD(UART_BAUD), .FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_50m(clk_50m), .reset(reset), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full),
    .tx(tx), .tx_busy(tx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents, bytes still owed on the line, and the
  // edge from which the transmitter can take the next byte.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  longint     edge_n = 0;
  longint     avail = 0;
  bit         busy_st = 1'b0;
  bit         dec_spoil = 1'b0;

  task automatic cycle(input logic wr, input logic [7:0] d);
    bit pop, acc, busy_prev;
    fifo_wr_en = wr;
    fifo_data_in = d;
    @(posedge clk_50m);
    edge_n++;
    busy_prev = busy_st;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      avail = 0;
      busy_st = 1'b0;
    end else begin
      pop = (edge_n >= avail) && (mq.size() > 0);
      acc = wr && (mq.size() < DEPTH);
      if (pop) begin
        void'(mq.pop_front());
        avail = edge_n + FB;
      end
      if (acc) begin
        mq.push_back(d);
        exp_q.push_back(d);
      end
      busy_st = (edge_n < avail);
    end
    #1;
    chk("fifo_empty", fifo_empty, mq.size() == 0);
    chk("fifo_full", fifo_full, mq.size() == DEPTH);
    chk("fifo_almost_full", fifo_almost_full, mq.size() >= DEPTH - 1);
    chk("tx_busy", tx_busy, reset ? 1'b0 : busy_prev);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((tx_busy || mq.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  // Serial decoder: finds the start edge and samples each bit at its centre.
  initial begin
    logic [7:0] b;
    logic st, sp, par;
    forever begin
      @(negedge clk_50m);
      if (!reset && tx === 1'b0) begin
        repeat (BD / 2) @(negedge clk_50m);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk_50m);
          b[i] = tx;
        end
        par = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (BD) @(negedge clk_50m);
        par = tx;
`endif
        repeat (BD) @(negedge clk_50m);
        sp = tx;
        if (dec_spoil) begin
          dec_spoil = 1'b0;
        end else begin
          chk("rx_start", st, 1'b0);
          chk("rx_stop", sp, 1'b1);
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", par, ^b);
`endif
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_spare: got frame %0h, expected no frame", b);
          end else begin
            chk("rx_byte", b, exp_q.pop_front());
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;  // {stop, d7..d0, start}
    logic       par;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [10:0] fr;
    longint e0;
    logic exp_tx;

    tbl[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
    tbl[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    tbl[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    tbl[3] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    tbl[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
    tbl[5] = '{8'h80, 10'b1_10000000_0, 1'b1};

    reset = 1'b1;
    fifo_wr_en = 1'b0;
    fifo_data_in = 8'h00;
    #5;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_afull", fifo_almost_full, 1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    reset = 1'b0;
    repeat (2) cycle(1'b0, 8'h00);

    // Single frames: exact line waveform, every cycle.
    for (int k = 0; k < 6; k++) begin
`ifdef UART_TX_PARITY_EN
      fr = {1'b1, tbl[k].par, tbl[k].frame[8:0]};
`else
      fr = {1'b0, tbl[k].frame};
`endif
      cycle(1'b1, tbl[k].d);
      for (int i = 1; i <= FB + 2; i++) begin
        cycle(1'b0, 8'h00);
        if (i == 1 || i == FB + 2) exp_tx = 1'b1;
        else exp_tx = fr[(i - 2) / BD];
        chk("frame_tx", tx, exp_tx);
      end
      wait_idle(4 * FB);
    end

    // Burst of five fills the FIFO behind the byte in flight; a sixth is dropped.
    cycle(1'b1, 8'h01);
    e0 = edge_n;
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03);
    cycle(1'b1, 8'h04);
    chk("afull_at_3", fifo_almost_full, 1'b1);
    cycle(1'b1, 8'h05);
    chk("full_after_burst", fifo_full, 1'b1);
    cycle(1'b1, 8'hFF);
    chk("full_after_drop", fifo_full, 1'b1);
    while (tx_busy && edge_n < e0 + 10 * FB) cycle(1'b0, 8'h00);
    chk("burst_len", 32'(edge_n - e0), 32'(2 + 5 * FB));
    wait_idle(4 * FB);

    // Push lands on the same edge as a stop-boundary pop with two queued.
    cycle(1'b1, 8'hA1);
    cycle(1'b1, 8'hB2);
    cycle(1'b1, 8'hC3);
    while (edge_n + 1 < avail) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h3C);
    chk("overlap_not_empty", fifo_empty, 1'b0);
    chk("overlap_not_afull", fifo_almost_full, 1'b0);
    cycle(1'b1, 8'h4D);
    chk("overlap_afull", fifo_almost_full, 1'b1);
    wait_idle(8 * FB);

    // Reset in the middle of data bit 3 of 0xAA.
    cycle(1'b1, 8'hAA);
    e0 = edge_n;
    while (edge_n < e0 + 2 + 4 * BD + BD / 2) cycle(1'b0, 8'h00);
    chk("pre_reset_bit3", tx, 1'b1);
    dec_spoil = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_empty", fifo_empty, 1'b1);
    chk("mid_rst_full", fifo_full, 1'b0);
    chk("mid_rst_afull", fifo_almost_full, 1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < FB + BD; i++) begin
      cycle(1'b0, 8'h00);
      chk("quiet_after_rst", tx, 1'b1);
    end
    cycle(1'b1, 8'h96);
    wait_idle(4 * FB);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 15) == 0, 8'($urandom));
    end
    wait_idle((DEPTH + 3) * FB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
